lc2k_multicycle_control: RTL and testbench
==========================================

# lc2k_multicycle_control

Multicycle control sequencer for the LC2K CPU, succeeding the single-cycle opcode-to-control decoder. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath strobes per state. It waits on a variable-latency memory handshake with a watchdog, supports halt and error terminal states, and counts retired instructions. It sits between the instruction register / ALU flags and the datapath muxes, register file and memory port.

## Interface
- MEM_TIMEOUT, 16, max consecutive wait cycles (mem_req=1, mem_ready=0) before ERROR; 0 disables watchdog
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  leave IDLE and begin fetching
- opcode  in  3  IR[24:22]; valid from the cycle after ir_load
- alu_eq  in  1  ALU equality flag (regA == regB)
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request active
- mem_we  out  1  1 = write (sw), 0 = read
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_load  out  1  load IR from memory read data
- pc_write  out  1  update PC this cycle
- pc_src  out  2  0 = PC+1, 1 = PC+1+offset, 2 = regA
- alu_srcb  out  1  1 = regB, 0 = sign-extended offset
- alu_op  out  2  0 = add, 1 = nor, 2 = compare
- reg_write  out  1  register-file write enable
- reg_dst  out  1  1 = destReg, 0 = regB
- reg_data_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+1
- halted  out  1  sticky, in HALT
- error  out  1  sticky, in ERROR (memory timeout)
- instr_count  out  CNT_W  retired instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR. Opcode encodings are the LC2K set: add 0, nor 1, lw 2, sw 3, beq 4, jalr 5, halt 6, noop 7.
- IDLE: all strobes 0. start=1 -> FETCH.
- FETCH: mem_req=1, mem_addr_sel=0. On mem_ready, ir_load=1 and pc_write=1 with pc_src=0, then -> DECODE.
- DECODE: latch opcode into op_q, the only opcode source afterward. halt -> HALT (retire). noop -> FETCH (retire). Others -> EXEC.
- EXEC add/nor: alu_srcb=1, alu_op=op_q[0] -> WB.
- EXEC lw/sw: alu_srcb=0, alu_op=0 -> MEM.
- EXEC beq: alu_srcb=1, alu_op=2. pc_write=alu_eq with pc_src=1. -> FETCH (retire).
- EXEC jalr: reg_write=1, reg_dst=0, reg_data_sel=2; pc_write=1, pc_src=2. -> FETCH (retire). regA==regB writes regB first, and the PC takes the pre-write regA.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=(op_q==sw). On mem_ready, lw -> WB and sw -> FETCH (retire).
- WB: reg_write=1. add/nor use reg_dst=1, reg_data_sel=0. lw uses reg_dst=0, reg_data_sel=1. -> FETCH (retire).
- HALT / ERROR: terminal until reset; all strobes 0; halted or error held at 1.
- Watchdog: wait_cnt clears on entry to FETCH/MEM and increments each cycle mem_req=1, mem_ready=0. When wait_cnt==MEM_TIMEOUT and mem_ready=0, the next state is ERROR. If mem_ready=1 in that same cycle, completion wins.
- instr_count increments by 1 on every retire, including halt, and wraps at 2^CNT_W.
- Strobes are combinational from registered state, op_q, alu_eq and mem_ready; no output depends on opcode outside DECODE.

## Timing
- Reset: state=IDLE, op_q=0, wait_cnt=0, instr_count=0, all outputs 0.
- Cycles with zero-wait memory, FETCH to next FETCH: noop 2, beq/jalr 3, add/nor/sw 4, lw 5. halt takes 2 cycles to reach HALT.
- Each memory wait cycle adds 1 cycle.
- mem_req stays high continuously until the cycle mem_ready=1. Other inputs are ignored while waiting.
- start is ignored outside IDLE.
- Reset mid-instruction returns the block to IDLE immediately (asynchronous). No partial strobe survives the reset.

## Structure
- Package lc2k_pkg holds the opcode localparams, the state enum, and the pc_src/alu_op/reg_data_sel encodings. The datapath uses the same package.
- Sub-module lc2k_mem_watchdog holds the wait counter and timeout compare, with inputs clear, req, ready and output expired.

## Test plan
- add with zero-wait memory: FETCH, DECODE, EXEC, WB -> reg_write=1, reg_dst=1, reg_data_sel=0 in cycle 4; instr_count 0->1.
- lw with mem_ready delayed 3 cycles in MEM: mem_req high for 4 MEM cycles, mem_addr_sel=1, then WB with reg_data_sel=1; total 8 cycles.
- beq with alu_eq=1 then with alu_eq=0: pc_write=1 with pc_src=1 in the first case; pc_write=0 in EXEC in the second; each 3 cycles.
- jalr: in EXEC, reg_write=1, reg_dst=0, reg_data_sel=2, pc_write=1, pc_src=2, all in one cycle.
- MEM_TIMEOUT=4 with mem_ready held 0 in FETCH -> ERROR after 5 wait cycles, error=1 sticky. A repeat with mem_ready=1 on the 5th cycle -> DECODE.
- halt, then start pulses -> halted=1 and instr_count=1 are held. An asynchronous reset mid-MEM returns all outputs to 0 and the state to IDLE.

Source files
------------

// File: rtl/lc2k_pkg.sv
// lc2k_pkg: shared LC2K opcodes, control FSM states and datapath mux encodings.
package lc2k_pkg;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_NOOP = 3'd7;
  localparam logic [1:0] PC_PLUS1  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_REGA   = 2'd2;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_NOR = 2'd1;
  localparam logic [1:0] ALU_CMP = 2'd2;
  localparam logic [1:0] RDS_ALU = 2'd0;
  localparam logic [1:0] RDS_MEM = 2'd1;
  localparam logic [1:0] RDS_PC1 = 2'd2;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
  } state_e;
endpackage

// File: rtl/lc2k_mem_watchdog.sv
// lc2k_mem_watchdog: counts consecutive memory wait cycles and flags a timeout.
module lc2k_mem_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic req,
  input  logic ready,
  output logic expired
);
  localparam int W = $clog2(MEM_TIMEOUT + 2);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : (req && !ready) ? cnt_q + W'(1) : cnt_q;
  // completion in the expiry cycle wins, hence the !ready term
  assign expired = (MEM_TIMEOUT != 0) && req && !ready && (cnt_q == W'(MEM_TIMEOUT));
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/lc2k_multicycle_control.sv
// lc2k_multicycle_control: multicycle LC2K sequencer driving datapath strobes per state.
module lc2k_multicycle_control
  import lc2k_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic             alu_eq,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_srcb,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic [1:0]       reg_data_sel,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);
  state_e state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [CNT_W-1:0] cnt_d;
  logic retire, expired, wd_clear, wd_req;
  assign wd_req = (state_q == S_FETCH) || (state_q == S_MEM);
  lc2k_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
    .clk(clk), .reset(reset), .clear(wd_clear), .req(wd_req), .ready(mem_ready), .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    retire = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load = 1'b0;
    pc_write = 1'b0;
    pc_src = PC_PLUS1;
    alu_srcb = 1'b0;
    alu_op = ALU_ADD;
    reg_write = 1'b0;
    reg_dst = 1'b0;
    reg_data_sel = RDS_ALU;
    halted = 1'b0;
    error = 1'b0;
    case (state_q)
      S_IDLE: state_d = start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
        pc_write = mem_ready;
        state_d = mem_ready ? S_DECODE : expired ? S_ERROR : S_FETCH;
      end
      S_DECODE: begin
        op_d = opcode;
        retire = (opcode == OP_HALT) || (opcode == OP_NOOP);
        state_d = (opcode == OP_HALT) ? S_HALT : (opcode == OP_NOOP) ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        alu_srcb = (op_q == OP_ADD) || (op_q == OP_NOR) || (op_q == OP_BEQ);
        alu_op = (op_q == OP_BEQ) ? ALU_CMP : (op_q == OP_NOR) ? ALU_NOR : ALU_ADD;
        reg_write = (op_q == OP_JALR);
        reg_data_sel = (op_q == OP_JALR) ? RDS_PC1 : RDS_ALU;
        pc_write = (op_q == OP_JALR) || ((op_q == OP_BEQ) && alu_eq);
        pc_src = (op_q == OP_JALR) ? PC_REGA : (op_q == OP_BEQ) ? PC_BRANCH : PC_PLUS1;
        retire = (op_q == OP_BEQ) || (op_q == OP_JALR);
        state_d = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : retire ? S_FETCH : S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we = (op_q == OP_SW);
        retire = mem_ready && (op_q == OP_SW);
        state_d = !mem_ready ? (expired ? S_ERROR : S_MEM) : (op_q == OP_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst = (op_q != OP_LW);
        reg_data_sel = (op_q == OP_LW) ? RDS_MEM : RDS_ALU;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      S_ERROR: error = 1'b1;
      default: state_d = S_IDLE;
    endcase
    wd_clear = (state_d == S_FETCH || state_d == S_MEM) && (state_d != state_q);
    cnt_d = instr_count + CNT_W'(retire);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      op_q <= '0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      instr_count <= cnt_d;
    end
endmodule

// File: tb/tb_lc2k_multicycle_control.sv
// tb_lc2k_multicycle_control: randomized instruction streams checked against per-instruction cycle/strobe totals.
module tb_lc2k_multicycle_control;
  import lc2k_pkg::*;
  localparam int TO = 4;
  localparam int CW = 4;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, alu_eq = 1'b0, mem_ready = 1'b0;
  logic [2:0] opcode = '0;
  logic mem_req, mem_we, mem_addr_sel, ir_load, pc_write, alu_srcb, reg_write, reg_dst, halted, error;
  logic [1:0] pc_src, alu_op, reg_data_sel;
  logic [CW-1:0] instr_count, exp_cnt;
  int tests = 0, fails = 0;

  lc2k_multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .alu_eq(alu_eq),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src), .alu_srcb(alu_srcb),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .reg_data_sel(reg_data_sel),
    .halted(halted), .error(error), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] strobes();
    return {mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_src, alu_srcb, alu_op,
            reg_write, reg_dst, reg_data_sel};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    mem_ready = 1'b0;
    #2 reset = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
  endtask

  // Runs one instruction for exactly its expected cycle count, acting as a memory
  // that answers after fw (fetch) / mw (data) wait cycles, then checks strobe totals.
  task automatic run_instr(input logic [2:0] op, input logic eq, input int fw, input int mw);
    int exp_cyc, n_req, n_we, n_asel, n_rw, n_pw, n_ir, pc_sum, reqrun, ndone;
    int e_pw, e_pcs, e_rw;
    logic rw_dst;
    logic [1:0] rw_sel;
    bit is_mem;
    is_mem = (op == OP_LW) || (op == OP_SW);
    exp_cyc = fw + ((op == OP_NOOP || op == OP_HALT) ? 2 : (op == OP_BEQ || op == OP_JALR) ? 3 :
                    (op == OP_LW) ? 5 : 4) + (is_mem ? mw : 0);
    {n_req, n_we, n_asel, n_rw, n_pw, n_ir, pc_sum, reqrun, ndone} = '0;
    rw_dst = 1'b0;
    rw_sel = 2'd0;
    for (int k = 1; k <= exp_cyc; k++) begin
      @(negedge clk);
      opcode = (k == fw + 2) ? op : 3'($urandom);
      start = 1'($urandom);
      alu_eq = eq;
      mem_ready = 1'b0;
      #1;
      if (k == 1) begin
        tests++;
        if (!(mem_req === 1'b1 && mem_addr_sel === 1'b0 && instr_count === exp_cnt)) begin
          fails++;
          $display("FAIL fetch_entry op=%0d: req=%b asel=%b count=%0d, required 1 0 %0d",
                   op, mem_req, mem_addr_sel, instr_count, exp_cnt);
        end
      end
      if (mem_req === 1'b1) begin
        reqrun++;
        mem_ready = (reqrun == ((ndone == 0) ? fw : mw) + 1);
      end else mem_ready = 1'($urandom);
      #1;
      if (mem_req) n_req++;
      if (mem_we) n_we++;
      if (mem_addr_sel) n_asel++;
      if (ir_load) n_ir++;
      if (pc_write) begin
        n_pw++;
        pc_sum += int'(pc_src);
      end
      if (reg_write) begin
        n_rw++;
        rw_dst = reg_dst;
        rw_sel = reg_data_sel;
      end
      if (k == fw + 3 && op != OP_NOOP && op != OP_HALT && op != OP_JALR) begin
        tests++;
        if (alu_srcb !== (op == OP_ADD || op == OP_NOR || op == OP_BEQ) ||
            alu_op !== ((op == OP_BEQ) ? 2'd2 : (op == OP_NOR) ? 2'd1 : 2'd0)) begin
          fails++;
          $display("FAIL exec_alu op=%0d: srcb=%b alu_op=%0d", op, alu_srcb, alu_op);
        end
      end
      if (mem_req && mem_ready) begin
        ndone++;
        reqrun = 0;
      end
    end
    e_pw = 1 + ((op == OP_JALR || (op == OP_BEQ && eq)) ? 1 : 0);
    e_pcs = (op == OP_JALR) ? 2 : (op == OP_BEQ && eq) ? 1 : 0;
    e_rw = (op == OP_ADD || op == OP_NOR || op == OP_LW || op == OP_JALR) ? 1 : 0;
    tests++;
    if (n_req != fw + 1 + (is_mem ? mw + 1 : 0) || n_asel != (is_mem ? mw + 1 : 0) ||
        n_we != ((op == OP_SW) ? mw + 1 : 0) || n_ir != 1) begin
      fails++;
      $display("FAIL mem_totals op=%0d fw=%0d mw=%0d: req=%0d asel=%0d we=%0d ir=%0d",
               op, fw, mw, n_req, n_asel, n_we, n_ir);
    end
    tests++;
    if (n_pw != e_pw || pc_sum != e_pcs) begin
      fails++;
      $display("FAIL pc_totals op=%0d eq=%b: writes=%0d src_sum=%0d, required %0d %0d",
               op, eq, n_pw, pc_sum, e_pw, e_pcs);
    end
    tests++;
    if (n_rw != e_rw || (e_rw == 1 && ({rw_dst, rw_sel} !==
        ((op == OP_LW) ? 3'b001 : (op == OP_JALR) ? 3'b010 : 3'b100)))) begin
      fails++;
      $display("FAIL reg_write op=%0d: writes=%0d dst=%b sel=%0d, required %0d", op, n_rw, rw_dst, rw_sel, e_rw);
    end
    exp_cnt++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (strobes() !== '0 || halted !== 1'b0 || error !== 1'b0 || instr_count !== '0) begin
      fails++;
      $display("FAIL reset_state: strobes=%h halted=%b error=%b count=%0d, required all 0",
               strobes(), halted, error, instr_count);
    end
    do_reset();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      mem_ready = 1'($urandom);
      opcode = 3'($urandom);
      #1;
      tests++;
      if (strobes() !== '0) begin
        fails++;
        $display("FAIL idle_quiet: strobes=%h, required 0", strobes());
      end
    end
    kick();
  endtask

  task automatic test_directed();
    run_instr(OP_ADD, 1'b0, 0, 0);
    run_instr(OP_LW, 1'b0, 0, 3);
    run_instr(OP_BEQ, 1'b1, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0);
    run_instr(OP_JALR, 1'b1, 0, 0);
    run_instr(OP_SW, 1'b0, 1, 2);
    run_instr(OP_NOOP, 1'b0, 0, 0);
    run_instr(OP_NOR, 1'b1, 2, 0);
    run_instr(OP_ADD, 1'b0, TO, 0);
    run_instr(OP_LW, 1'b0, 0, TO);
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      if (op == OP_HALT) op = OP_NOOP;
      run_instr(op, 1'($urandom), int'($urandom_range(0, TO)), int'($urandom_range(0, TO)));
    end
  endtask

  task automatic test_timeout();
    do_reset();
    kick();
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      start = 1'b0;
      mem_ready = 1'b0;
      opcode = 3'($urandom);
      #1;
      tests++;
      if (mem_req !== 1'b1 || error !== 1'b0) begin
        fails++;
        $display("FAIL wait_cycle%0d: req=%b error=%b, required 1 0", k, mem_req, error);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      mem_ready = 1'($urandom);
      #1;
      tests++;
      if (error !== 1'b1 || halted !== 1'b0 || strobes() !== '0 || instr_count !== '0) begin
        fails++;
        $display("FAIL error_sticky: error=%b halted=%b strobes=%h count=%0d", error, halted, strobes(), instr_count);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    kick();
    run_instr(OP_ADD, 1'b0, 0, 0);
    run_instr(OP_HALT, 1'b0, int'($urandom_range(0, 2)), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = i[0];
      mem_ready = 1'($urandom);
      #1;
      tests++;
      if (halted !== 1'b1 || error !== 1'b0 || strobes() !== '0 || instr_count !== exp_cnt) begin
        fails++;
        $display("FAIL halt_sticky: halted=%b error=%b strobes=%h count=%0d, required 1 0 0 %0d",
                 halted, error, strobes(), instr_count, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    kick();
    run_instr(OP_ADD, 1'b0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      opcode = (k == 2) ? OP_LW : 3'($urandom);
      mem_ready = (k == 1);
      #1;
      if (k >= 4) begin
        tests++;
        if (mem_req !== 1'b1 || mem_addr_sel !== 1'b1 || mem_we !== 1'b0) begin
          fails++;
          $display("FAIL lw_mem_wait: req=%b asel=%b we=%b, required 1 1 0", mem_req, mem_addr_sel, mem_we);
        end
      end
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (strobes() !== '0 || halted !== 1'b0 || error !== 1'b0 || instr_count !== '0) begin
      fails++;
      $display("FAIL async_reset: strobes=%h count=%0d, required 0 0", strobes(), instr_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      tests++;
      if (strobes() !== '0) begin
        fails++;
        $display("FAIL idle_after_reset: strobes=%h, required 0", strobes());
      end
    end
  endtask

  initial begin
    exp_cnt = '0;
    test_reset();
    test_idle();
    test_directed();
    test_random();
    test_timeout();
    test_halt();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
